// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the two-master memory arbiter
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    // Default widths when the build does not override them.
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_BLK_W  = 256;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_RESP = 2'd2
    } arb_state_t;

    // After a completed transaction the other master gets priority.
    function automatic logic rr_after(input logic granted);
        return ~granted;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational 2-way round-robin winner
//
// Ports:
//   req0, req1 : master requests
//   rr_ptr     : master preferred when both request
//   valid      : at least one master requests
//   winner     : index of the selected master (meaningful when valid)
module mem_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    // A lone requester always wins; rr_ptr only breaks ties.
    assign winner = (req0 && req1) ? rr_ptr : req1;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one block memory port between two caches
//
// Optional feature macro: MEM_ARB_STATS_EN (adds saturating grant/conflict counters).
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   mN_req/rw/addr/wdata     : master N request (held until mN_resp)
//   mN_ready                 : arbiter idle and able to take a request
//   mN_resp, mN_rdata        : completion pulse (granted master only), read data broadcast
//   mem_req/rw/addr/wdata    : request to main memory (registered)
//   mem_ready, mem_resp      : memory accept and completion
//   mem_rdata                : memory read block
//   dbg_state, dbg_grant     : FSM state, current or last granted master
//   stat_grants0/1, stat_conflicts : statistics (MEM_ARB_STATS_EN only)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BLK_W  = DEF_BLK_W
`ifdef MEM_ARB_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m0_req,
    input  logic                       m0_rw,
    input  logic [ADDR_W-1:0]          m0_addr,
    input  logic [BLK_W-1:0]           m0_wdata,
    output logic                       m0_ready,
    output logic                       m0_resp,
    output logic [BLK_W-1:0]           m0_rdata,
    input  logic                       m1_req,
    input  logic                       m1_rw,
    input  logic [ADDR_W-1:0]          m1_addr,
    input  logic [BLK_W-1:0]           m1_wdata,
    output logic                       m1_ready,
    output logic                       m1_resp,
    output logic [BLK_W-1:0]           m1_rdata,
    output logic                       mem_req,
    output logic                       mem_rw,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [BLK_W-1:0]           mem_wdata,
    input  logic                       mem_ready,
    input  logic                       mem_resp,
    input  logic [BLK_W-1:0]           mem_rdata,
    output logic [ARB_STATE_WIDTH-1:0] dbg_state,
    output logic                       dbg_grant
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]           stat_grants0,
    output logic [CNT_W-1:0]           stat_grants1,
    output logic [CNT_W-1:0]           stat_conflicts
`endif
);

    arb_state_t        state, state_d;
    logic              rr_ptr, rr_ptr_d;
    logic              grant, grant_d;
    logic              latch_en;
    logic              pick_valid, pick_winner;
    logic              grant_req;
    logic              mem_req_q;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [BLK_W-1:0]  lat_wdata;

    mem_arb_rr_pick u_pick (
        .req0   (m0_req),
        .req1   (m1_req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign grant_req = grant ? m1_req : m0_req;

    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        grant_d  = grant;
        latch_en = 1'b0;
        m0_resp  = 1'b0;
        m1_resp  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_ISSUE;
                    grant_d  = pick_winner;
                    latch_en = 1'b1;
                end
            end
            ARB_ISSUE: begin
                // A handshake wins over a simultaneous request drop: once memory
                // has accepted, the transaction must be seen through.
                if (mem_ready) begin
                    state_d = ARB_WAIT_RESP;
                end else if (!grant_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_RESP: begin
                if (mem_resp) begin
                    m0_resp  = ~grant;
                    m1_resp  = grant;
                    rr_ptr_d = rr_after(grant);
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= 1'b0;
            grant     <= 1'b0;
            mem_req_q <= 1'b0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant     <= grant_d;
            mem_req_q <= (state_d == ARB_ISSUE);
            if (latch_en) begin
                lat_rw    <= pick_winner ? m1_rw    : m0_rw;
                lat_addr  <= pick_winner ? m1_addr  : m0_addr;
                lat_wdata <= pick_winner ? m1_wdata : m0_wdata;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_rw    = lat_rw;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign m0_ready  = (state == ARB_IDLE);
    assign m1_ready  = (state == ARB_IDLE);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;
    assign dbg_state = state;
    assign dbg_grant = grant;

`ifdef MEM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_g0, cnt_g1, cnt_cf;
    logic             conflict;

    assign conflict = (state == ARB_IDLE) && m0_req && m1_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_g0 <= '0;
            cnt_g1 <= '0;
            cnt_cf <= '0;
        end else begin
            if (latch_en && !pick_winner && (cnt_g0 != '1)) cnt_g0 <= cnt_g0 + CNT_W'(1);
            if (latch_en &&  pick_winner && (cnt_g1 != '1)) cnt_g1 <= cnt_g1 + CNT_W'(1);
            if (conflict && (cnt_cf != '1))                  cnt_cf <= cnt_cf + CNT_W'(1);
        end
    end

    assign stat_grants0   = cnt_g0;
    assign stat_grants1   = cnt_g1;
    assign stat_conflicts = cnt_cf;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int BW = 32;
    localparam logic [BW-1:0] W0 = 32'h1357_9BDF;
    localparam logic [BW-1:0] W1 = 32'hA5A5_A5A5;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_rw, m1_req, m1_rw;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [BW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m0_resp, m1_ready, m1_resp;
    logic [BW-1:0] m0_rdata, m1_rdata;
    logic          mem_req, mem_rw, mem_ready, mem_resp;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;
    logic          dbg_grant;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   stat_grants0, stat_grants1, stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .BLK_W(BW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state), .dbg_grant(dbg_grant)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
        .stat_conflicts(stat_conflicts)
`endif
    );

    typedef struct {
        logic          r0, rw0;
        logic [AW-1:0] a0;
        logic          r1, rw1;
        logic [AW-1:0] a1;
        logic          mrdy, mresp;
        logic [BW-1:0] rd;
        logic          e_mreq, e_mrw;
        logic [AW-1:0] e_maddr;
        logic [BW-1:0] e_wd;
        logic          e_rs0, e_rs1, e_rdy;
        logic [1:0]    e_st;
        logic          e_g;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r0, input logic rw0, input logic [AW-1:0] a0,
        input logic r1, input logic rw1, input logic [AW-1:0] a1,
        input logic mrdy, input logic mresp, input logic [BW-1:0] rd,
        input logic emreq, input logic emrw, input logic [AW-1:0] emaddr, input logic [BW-1:0] ewd,
        input logic ers0, input logic ers1, input logic erdy, input logic [1:0] est, input logic eg);
        vec_t v;
        v.r0 = r0; v.rw0 = rw0; v.a0 = a0; v.r1 = r1; v.rw1 = rw1; v.a1 = a1;
        v.mrdy = mrdy; v.mresp = mresp; v.rd = rd;
        v.e_mreq = emreq; v.e_mrw = emrw; v.e_maddr = emaddr; v.e_wd = ewd;
        v.e_rs0 = ers0; v.e_rs1 = ers1; v.e_rdy = erdy; v.e_st = est; v.e_g = eg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1; m0_rw = 1'b0; m1_rw = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wdata = W0; m1_wdata = W1;
        mem_ready = 1'b0; mem_resp = 1'b1; mem_rdata = '0;

        // Reset held with both masters requesting and a stray memory response.
        repeat (3) @(negedge clk);
        #1;
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset m0_resp", 32'(m0_resp), 32'd0);
        chk("reset m1_resp", 32'(m1_resp), 32'd0);
        chk("reset dbg_state", 32'(dbg_state), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0; mem_resp = 1'b0;
        rst = 1'b1;

        //       r0 rw0 a0      r1 rw1 a1      rdy rsp rdata          mreq mrw maddr  wdata rs0 rs1 rdy st  g
        vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0,0,32'h0,          0,0,16'h0000,32'h0, 0,0,1,2'd0,0));
        vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 1,0,32'h0,          1,0,16'h0040,W0,    0,0,0,2'd1,0));
        vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0,0,32'h0,          0,0,16'h0040,W0,    0,0,0,2'd2,0));
        vecs.push_back(mk(1,0,16'h0040, 0,0,16'h0000, 0,1,32'hCAFE_0040,  0,0,16'h0040,W0,    1,0,0,2'd2,0));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,0,32'h0,          0,0,16'h0040,W0,    0,0,1,2'd0,0));
        // m1 write while m0 idle
        vecs.push_back(mk(0,0,16'h0000, 1,1,16'h0080, 0,0,32'h0,          0,0,16'h0040,W0,    0,0,1,2'd0,0));
        vecs.push_back(mk(0,0,16'h0000, 1,1,16'h0080, 1,0,32'h0,          1,1,16'h0080,W1,    0,0,0,2'd1,1));
        vecs.push_back(mk(0,0,16'h0000, 1,1,16'h0080, 0,1,32'hBEEF_0080,  0,1,16'h0080,W1,    0,1,0,2'd2,1));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,0,32'h0,          0,1,16'h0080,W1,    0,0,1,2'd0,1));
        // contention: four back-to-back transactions, M0,M1,M0,M1
        for (int t = 0; t < 4; t++) begin
            logic          g;
            logic          gprev;
            logic [AW-1:0] ga;
            logic [AW-1:0] pa;
            logic [BW-1:0] gw;
            logic [BW-1:0] pw;
            logic          prw;
            g     = t[0];
            gprev = (t == 0) ? 1'b1 : ~g;
            ga    = g ? 16'h0180 : 16'h0100;
            pa    = (t == 0) ? 16'h0080 : (g ? 16'h0100 : 16'h0180);
            gw    = g ? W1 : W0;
            pw    = (t == 0) ? W1 : (g ? W0 : W1);
            prw   = (t == 0);
            vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0180, 0,0,32'h0,      0,prw,pa,pw, 0,0,1,2'd0,gprev));
            vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0180, 1,0,32'h0,      1,0,ga,gw,   0,0,0,2'd1,g));
            vecs.push_back(mk(1,0,16'h0100, 1,0,16'h0180, 0,1,32'h1000+t, 0,0,ga,gw,   ~g,g,0,2'd2,g));
        end
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,0,32'h0,          0,0,16'h0180,W1,    0,0,1,2'd0,1));
        // stray mem_resp while idle
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,1,32'h7777_7777,  0,0,16'h0180,W1,    0,0,1,2'd0,1));
        vecs.push_back(mk(0,0,16'h0000, 0,0,16'h0000, 0,0,32'h0,          0,0,16'h0180,W1,    0,0,1,2'd0,1));

        foreach (vecs[i]) begin
            @(negedge clk);
            m0_req = vecs[i].r0; m0_rw = vecs[i].rw0; m0_addr = vecs[i].a0;
            m1_req = vecs[i].r1; m1_rw = vecs[i].rw1; m1_addr = vecs[i].a1;
            mem_ready = vecs[i].mrdy; mem_resp = vecs[i].mresp; mem_rdata = vecs[i].rd;
            #1;
            chk($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_mreq));
            chk($sformatf("v%0d mem_rw", i),    32'(mem_rw),    32'(vecs[i].e_mrw));
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d m0_resp", i),   32'(m0_resp),   32'(vecs[i].e_rs0));
            chk($sformatf("v%0d m1_resp", i),   32'(m1_resp),   32'(vecs[i].e_rs1));
            chk($sformatf("v%0d m0_ready", i),  32'(m0_ready),  32'(vecs[i].e_rdy));
            chk($sformatf("v%0d m1_ready", i),  32'(m1_ready),  32'(vecs[i].e_rdy));
            chk($sformatf("v%0d dbg_state", i), 32'(dbg_state), 32'(vecs[i].e_st));
            chk($sformatf("v%0d dbg_grant", i), 32'(dbg_grant), 32'(vecs[i].e_g));
            if (vecs[i].e_rs0) chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].rd);
            if (vecs[i].e_rs1) chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].rd);
        end

`ifdef MEM_ARB_STATS_EN
        chk("stat_grants0", 32'(stat_grants0), 32'd3);
        chk("stat_grants1", 32'(stat_grants1), 32'd3);
        chk("stat_conflicts", 32'(stat_conflicts), 32'd4);
`endif

        // Backpressure: mem_ready low for 5 cycles, request held. rr_ptr is 0 here.
        @(negedge clk);
        m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0200; m1_req = 1'b0;
        mem_ready = 1'b0; mem_resp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk($sformatf("bp%0d mem_req", k), 32'(mem_req), 32'd1);
            chk($sformatf("bp%0d dbg_state", k), 32'(dbg_state), 32'd1);
        end
        chk("bp mem_addr", 32'(mem_addr), 32'h0200);
        m0_req = 1'b0;
        @(negedge clk); #1;
        chk("bp abort state", 32'(dbg_state), 32'd0);
        chk("bp abort mem_req", 32'(mem_req), 32'd0);

        // Abort in cycle 3 of the issue phase.
        m0_req = 1'b1;
        @(negedge clk); #1;
        chk("ab c1 mem_req", 32'(mem_req), 32'd1);
        @(negedge clk); #1;
        chk("ab c2 mem_req", 32'(mem_req), 32'd1);
        @(negedge clk);
        m0_req = 1'b0;
        @(negedge clk); #1;
        chk("ab idle state", 32'(dbg_state), 32'd0);
        chk("ab idle ready", 32'(m0_ready), 32'd1);

        // rr_ptr untouched by the aborts: M0 still preferred under contention.
        m0_req = 1'b1; m1_req = 1'b1; m1_addr = 16'h0280;
        @(negedge clk); #1;
        chk("post-abort grant", 32'(dbg_grant), 32'd0);
        chk("post-abort state", 32'(dbg_state), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_resp = 1'b1;
        #1;
        chk("post-abort m0_resp", 32'(m0_resp), 32'd1);
        chk("post-abort m1_resp", 32'(m1_resp), 32'd0);
        @(negedge clk);
        m0_req = 1'b0; mem_resp = 1'b0;
        @(negedge clk); #1;
        chk("m1 turn grant", 32'(dbg_grant), 32'd1);
        chk("m1 turn mem_addr", 32'(mem_addr), 32'h0280);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("pre-reset state", 32'(dbg_state), 32'd2);

        // Asynchronous reset in WAIT_RESP, rr_ptr=1 and grant=1 beforehand.
        #2;
        rst = 1'b0;
        #1;
        chk("mid reset state", 32'(dbg_state), 32'd0);
        chk("mid reset grant", 32'(dbg_grant), 32'd0);
        chk("mid reset mem_req", 32'(mem_req), 32'd0);
        m0_req = 1'b1; m1_req = 1'b1; mem_resp = 1'b1;
        @(negedge clk); #1;
        chk("in reset m1_resp", 32'(m1_resp), 32'd0);
        chk("in reset mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stray m0_resp", 32'(m0_resp), 32'd0);
        chk("stray m1_resp", 32'(m1_resp), 32'd0);
        chk("release ready", 32'(m0_ready), 32'd1);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("first grant after reset", 32'(dbg_grant), 32'd0);
        chk("first issue after reset", 32'(mem_req), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
